// File: rtl/disk_pkg.sv
// Shared definitions for the disk write-path logic: decoder states, GCR framing
// bytes and the default 7 MHz bit-cell timing.
package disk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } dec_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    localparam logic [7:0] PKT_BEGIN = 8'hC3;

    localparam int CELL_CLKS_7M = 28;
    localparam int HALF_CLKS_7M = 14;

    function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
        return {sr[6:0], b};
    endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable
// reset value so inactive-high strobes come out of reset deasserted.
module bit_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic fclk,
    input  logic _reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            // NOTE: non-blocking so the second stage samples the pre-edge value of the first.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/wrdata_decoder.sv
// Recovers GCR nibbles from the IWM serial write stream (one transition per 1-bit).
// Optional packet-start hunt enabled by defining WRDATA_DECODER_SYNC_HUNT_EN.
module wrdata_decoder
    import disk_pkg::*;
#(
    parameter int CELL_CLKS      = CELL_CLKS_7M,
    parameter int HALF_CLKS      = HALF_CLKS_7M,
    parameter int MAX_ZERO_CELLS = 8,
    parameter int COUNT_W        = 10
) (
    input  logic               fclk,
    input  logic               _reset,
    input  logic               wrdata,
    input  logic               _wrreq,
    output logic [7:0]         byte_out,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               overflow,
    output logic               active,
    output logic [COUNT_W-1:0] byte_count
);

    localparam int ZC_W = $clog2(MAX_ZERO_CELLS + 1);
    localparam logic [5:0]      HALF_T  = 6'(HALF_CLKS);
    localparam logic [5:0]      TMO_T   = 6'(CELL_CLKS + HALF_CLKS);
    localparam logic [ZC_W-1:0] ZC_LAST = ZC_W'(MAX_ZERO_CELLS - 1);

    logic wrdata_s, wrdata_d, wrreq_s, wr_edge;

    bit_sync2 #(.RST_VAL(1'b0)) u_sync_wrdata (
        .fclk   (fclk),
        ._reset (_reset),
        .d      (wrdata),
        .q      (wrdata_s)
    );

    bit_sync2 #(.RST_VAL(1'b1)) u_sync_wrreq (
        .fclk   (fclk),
        ._reset (_reset),
        .d      (_wrreq),
        .q      (wrreq_s)
    );

    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) wrdata_d <= 1'b0;
        else         wrdata_d <= wrdata_s;
    end

    assign wr_edge = wrdata_s ^ wrdata_d;

    dec_state_t      state;
    logic [5:0]      cell_timer;
    logic [ZC_W-1:0] zero_cells;
    logic [7:0]      shifter;

    logic       shift_en, shift_bit, nib_done, deliver, session_start;
    logic [7:0] shifted;

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        if (state == RUN && !wrreq_s) begin
            if (wr_edge) begin
                shift_en  = (cell_timer >= HALF_T);
                shift_bit = 1'b1;
            end else if (cell_timer == TMO_T) begin
                shift_en = 1'b1;
            end
        end
        shifted  = shift_in(shifter, shift_bit);
        nib_done = shift_en && shifted[7];
    end

    assign session_start = (state == IDLE) && !wrreq_s;

    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) begin
            state      <= IDLE;
            cell_timer <= '0;
            zero_cells <= '0;
            shifter    <= '0;
            active     <= 1'b0;
        end else if (wrreq_s) begin
            state      <= IDLE;
            cell_timer <= '0;
            zero_cells <= '0;
            shifter    <= '0;
            active     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= ALIGN;
                    shifter <= '0;
                end
                ALIGN: begin
                    if (wr_edge) begin
                        cell_timer <= '0;
                        zero_cells <= '0;
                        state      <= RUN;
                        active     <= 1'b1;
                    end
                end
                RUN: begin
                    if (wr_edge) begin
                        cell_timer <= '0;
                        if (shift_en) zero_cells <= '0;
                    end else if (shift_en) begin
                        // A missing transition is a 0; re-centre the timer mid-cell.
                        cell_timer <= HALF_T;
                        zero_cells <= zero_cells + ZC_W'(1);
                    end else begin
                        cell_timer <= cell_timer + 6'd1;
                    end

                    if (shift_en && !wr_edge && zero_cells == ZC_LAST) begin
                        state   <= ALIGN;
                        active  <= 1'b0;
                        shifter <= '0;
                    end else if (shift_en) begin
                        shifter <= nib_done ? 8'h00 : shifted;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

`ifdef WRDATA_DECODER_SYNC_HUNT_EN
    logic hunt_locked, hunt_seen_sync;

    // Nibbles are swallowed until PKT_BEGIN directly follows one or more SYNC_BYTEs.
    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) begin
            hunt_locked    <= 1'b0;
            hunt_seen_sync <= 1'b0;
        end else if (state == ALIGN && wr_edge && !wrreq_s) begin
            hunt_locked    <= 1'b0;
            hunt_seen_sync <= 1'b0;
        end else if (nib_done && !hunt_locked) begin
            if (shifted == PKT_BEGIN && hunt_seen_sync) hunt_locked <= 1'b1;
            hunt_seen_sync <= (shifted == SYNC_BYTE);
        end
    end

    assign deliver = nib_done && (hunt_locked || (shifted == PKT_BEGIN && hunt_seen_sync));
`else
    assign deliver = nib_done;
`endif

    always_ff @(posedge fclk or negedge _reset) begin
        if (!_reset) begin
            byte_out   <= '0;
            byte_valid <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
        end else begin
            if (session_start) begin
                overflow   <= 1'b0;
                byte_count <= '0;
            end
            if (deliver) begin
                if (!byte_valid || byte_ready) begin
                    byte_out   <= shifted;
                    byte_valid <= 1'b1;
                    if (byte_count != '1) byte_count <= byte_count + COUNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end else if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end
        end
    end

endmodule
